// File: rtl/hamming_distance.sv
// Three-stage pipelined Hamming distance: popcount(x ^ y), one result per clock.
// Stages: XOR register, per-byte popcount register, adder-tree sum into res.
module hamming_distance #(
  parameter int WIDTH = 32,
  parameter int RES_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [RES_W-1:0] res,
  output logic             res_valid
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0]     d1_d, d1_q;
  logic [NB-1:0][3:0]   cnt_d, cnt_q;
  logic [RES_W-1:0]     res_d, res_q;
  logic [1:0]           vld_d, vld_q;
  logic                 res_valid_d, res_valid_q;

  always_comb begin
    d1_d = x ^ y;

    cnt_d = '0;
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < 8; i++) begin
        cnt_d[b] = cnt_d[b] + {3'b000, d1_q[8*b+i]};
      end
    end

    // Byte counts are at most 8, so the sum can never exceed WIDTH < 2^RES_W.
    res_d = '0;
    for (int b = 0; b < NB; b++) begin
      res_d = res_d + RES_W'(cnt_q[b]);
    end

    // Two-bit token shifter tracks fill of stages 1-2; the final flop aligns it with res.
    vld_d       = {vld_q[0], 1'b1};
    res_valid_d = vld_q[1];
  end

  // NOTE: every pipeline register is cleared by rst_n so res reads 0 (never X) until
  // valid data arrives; state is updated with <= so all stages shift on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q        <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      vld_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      d1_q        <= d1_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      vld_q       <= vld_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res       = res_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_hamming_distance.sv
// Directed bench for hamming_distance with a scoreboard queue of expected popcounts.
// Each sampled pair pushes its expected distance; the third push pops the result due now.
module tb_hamming_distance;

  localparam int WIDTH = 32;
  localparam int RES_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic [RES_W-1:0] res;
  logic             res_valid;

  int total = 0;
  int bad   = 0;
  int unsigned sb[$];

  hamming_distance #(.WIDTH(WIDTH), .RES_W(RES_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .res       (res),
    .res_valid (res_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: record what the DUT samples, then check outputs 1 ns after the edge.
  task automatic cycle(input string tag);
    int unsigned exp_res;
    logic        exp_vld;
    @(posedge clk);
    if (rst_n) sb.push_back($countones(x ^ y));
    #1;
    if (sb.size() == 3) begin
      exp_res = sb.pop_front();
      exp_vld = 1'b1;
    end else begin
      exp_res = 0;
      exp_vld = 1'b0;
    end
    check({tag, ".res"}, 32'(res), exp_res);
    check({tag, ".valid"}, 32'(res_valid), 32'(exp_vld));
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int n, input string tag);
    x = a;
    y = b;
    repeat (n) cycle(tag);
  endtask

  initial begin
    // Reset held for five clocks with random operands.
    #1;
    check("rst_async.res", 32'(res), 0);
    check("rst_async.valid", 32'(res_valid), 0);
    for (int i = 0; i < 5; i++) drive($urandom, $urandom, 1, "reset_hold");

    // Release between edges, then hold x=10, y=5; valid on the third edge.
    #2 rst_n = 1'b1;
    drive(32'd10, 32'd5, 6, "basic_10_5");

    // Boundaries.
    drive(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, "equal");
    drive(32'h0000_0000, 32'hFFFF_FFFF, 3, "all_diff");
    drive(32'h8000_0000, 32'h0000_0000, 3, "msb_only");

    // Byte-boundary walk.
    for (int k = 0; k < 32; k++) drive(32'h1 << k, 32'h0, 1, "walk_bit");
    for (int j = 0; j < 4; j++) drive(32'hFF << (8 * j), 32'h0, 1, "walk_byte");

    // Back-to-back random stream.
    for (int i = 0; i < 1000; i++) drive($urandom, $urandom, 1, "stream");

    // Asynchronous reset pulse mid-stream, away from the clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_async.res", 32'(res), 0);
    check("mid_rst_async.valid", 32'(res_valid), 0);
    sb.delete();
    drive($urandom, $urandom, 1, "mid_rst_low");
    #3 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) drive($urandom, $urandom, 1, "post_rst");
    drive(32'h0F0F_0F0F, 32'hF0F0_F0F0, 4, "post_rst_full");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
